// File: rtl/src_datapath_pkg.sv
// Shared definitions for the Mini-SRC phase-1 datapath: register width and
// ALU_Control opcode encoding.
package src_datapath_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SHR  = 5'b00100;
    localparam logic [4:0] ALU_SHRA = 5'b00101;
    localparam logic [4:0] ALU_SHL  = 5'b00110;
    localparam logic [4:0] ALU_ROR  = 5'b00111;
    localparam logic [4:0] ALU_ROL  = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b01001;
    localparam logic [4:0] ALU_DIV  = 5'b01010;
    localparam logic [4:0] ALU_NEG  = 5'b01011;
    localparam logic [4:0] ALU_NOT  = 5'b01100;

endpackage

// File: rtl/src_datapath_register32.sv
// Generic datapath register: loads d on the rising edge when enabled,
// cleared asynchronously while clear is low.
module register32
    import src_datapath_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/src_datapath.sv
// Mini-SRC phase-1 single-bus datapath: register file, special registers,
// priority bus mux and single-cycle ALU, all driven by external strobes.
module src_datapath
    import src_datapath_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             Zhighin,
    input  logic             Zlowin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             In_Portin,
    input  logic             Coutin,
    input  logic             Read,
    input  logic             IRin,
    input  logic             MARin,
    input  logic             Yin,
    input  logic             Zin,
    input  logic             R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             In_Portout,
    input  logic             Coutout,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [4:0]       ALU_Control,
    output logic [WIDTH-1:0] Out_Portout
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] r_q [16];
    logic [15:0]      r_out;
    logic [WIDTH-1:0] hi_q, lo_q, zhigh_q, zlow_q, pc_q, mdr_q, in_port_q, c_q;
    logic [WIDTH-1:0] ir_q, mar_q, y_q;
    logic [WIDTH-1:0] mdr_d, zhigh_d, zlow_d;
    logic [2*WIDTH-1:0] alu_res;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // ------------------------------------------------------------------
    // General registers
    // ------------------------------------------------------------------
    register32 R0  (.clock(clock), .clear(clear), .enable(R0in),  .d(bus), .q(r_q[0]));
    register32 R1  (.clock(clock), .clear(clear), .enable(R1in),  .d(bus), .q(r_q[1]));
    register32 R2  (.clock(clock), .clear(clear), .enable(R2in),  .d(bus), .q(r_q[2]));
    register32 R3  (.clock(clock), .clear(clear), .enable(R3in),  .d(bus), .q(r_q[3]));
    register32 R4  (.clock(clock), .clear(clear), .enable(R4in),  .d(bus), .q(r_q[4]));
    register32 R5  (.clock(clock), .clear(clear), .enable(R5in),  .d(bus), .q(r_q[5]));
    register32 R6  (.clock(clock), .clear(clear), .enable(R6in),  .d(bus), .q(r_q[6]));
    register32 R7  (.clock(clock), .clear(clear), .enable(R7in),  .d(bus), .q(r_q[7]));
    register32 R8  (.clock(clock), .clear(clear), .enable(R8in),  .d(bus), .q(r_q[8]));
    register32 R9  (.clock(clock), .clear(clear), .enable(R9in),  .d(bus), .q(r_q[9]));
    register32 R10 (.clock(clock), .clear(clear), .enable(R10in), .d(bus), .q(r_q[10]));
    register32 R11 (.clock(clock), .clear(clear), .enable(R11in), .d(bus), .q(r_q[11]));
    register32 R12 (.clock(clock), .clear(clear), .enable(R12in), .d(bus), .q(r_q[12]));
    register32 R13 (.clock(clock), .clear(clear), .enable(R13in), .d(bus), .q(r_q[13]));
    register32 R14 (.clock(clock), .clear(clear), .enable(R14in), .d(bus), .q(r_q[14]));
    register32 R15 (.clock(clock), .clear(clear), .enable(R15in), .d(bus), .q(r_q[15]));

    // ------------------------------------------------------------------
    // Special registers
    // ------------------------------------------------------------------
    assign mdr_d = Read ? Mdatain : bus;

    // A full ALU load takes precedence over a half load from the bus.
    assign zhigh_d = Zin ? alu_res[2*WIDTH-1:WIDTH] : bus;
    assign zlow_d  = Zin ? alu_res[WIDTH-1:0]       : bus;

    register32 hi_reg      (.clock(clock), .clear(clear), .enable(HIin),
                            .d(bus),     .q(hi_q));
    register32 lo_reg      (.clock(clock), .clear(clear), .enable(LOin),
                            .d(bus),     .q(lo_q));
    register32 zhigh_reg   (.clock(clock), .clear(clear), .enable(Zin | Zhighin),
                            .d(zhigh_d), .q(zhigh_q));
    register32 zlow_reg    (.clock(clock), .clear(clear), .enable(Zin | Zlowin),
                            .d(zlow_d),  .q(zlow_q));
    register32 pc_reg      (.clock(clock), .clear(clear), .enable(PCin),
                            .d(bus),     .q(pc_q));
    register32 mdr_reg     (.clock(clock), .clear(clear), .enable(MDRin),
                            .d(mdr_d),   .q(mdr_q));
    register32 in_port_reg (.clock(clock), .clear(clear), .enable(In_Portin),
                            .d(bus),     .q(in_port_q));
    register32 c_reg       (.clock(clock), .clear(clear), .enable(Coutin),
                            .d(bus),     .q(c_q));
    register32 ir_reg      (.clock(clock), .clear(clear), .enable(IRin),
                            .d(bus),     .q(ir_q));
    register32 mar_reg     (.clock(clock), .clear(clear), .enable(MARin),
                            .d(bus),     .q(mar_q));
    register32 y_reg       (.clock(clock), .clear(clear), .enable(Yin),
                            .d(bus),     .q(y_q));

    // ------------------------------------------------------------------
    // Bus: sources applied lowest priority first so the highest one wins
    // ------------------------------------------------------------------
    always_comb begin
        bus = '0;
        if (Coutout)    bus = c_q;
        if (In_Portout) bus = in_port_q;
        if (MDRout)     bus = mdr_q;
        if (PCout)      bus = pc_q;
        if (Zlowout)    bus = zlow_q;
        if (Zhighout)   bus = zhigh_q;
        if (LOout)      bus = lo_q;
        if (HIout)      bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = r_q[i];
        end
    end

    assign Out_Portout = bus;

    // ------------------------------------------------------------------
    // ALU: A = Y, B = bus
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          alu_a, alu_b;
    logic [4:0]                shamt;
    logic [5:0]                shinv;
    logic signed [2*WIDTH-1:0] a_ext, b_ext, product;
    logic signed [WIDTH-1:0]   quot, rem;

    assign alu_a = y_q;
    assign alu_b = bus;
    assign shamt = alu_b[4:0];
    assign shinv = 6'd32 - {1'b0, shamt};
    assign a_ext = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
    assign b_ext = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    assign product = a_ext * b_ext;

    always_comb begin
        quot = '0;
        rem  = '0;
        if (alu_b != '0) begin
            quot = $signed(alu_a) / $signed(alu_b);
            rem  = $signed(alu_a) % $signed(alu_b);
        end
    end

    always_comb begin
        alu_res = '0;
        if (IncPC) begin
            alu_res = {{WIDTH{1'b0}}, alu_b + 32'd1};
        end else begin
            case (ALU_Control)
                ALU_ADD:  alu_res = {{WIDTH{1'b0}}, alu_a + alu_b};
                ALU_SUB:  alu_res = {{WIDTH{1'b0}}, alu_a - alu_b};
                ALU_AND:  alu_res = {{WIDTH{1'b0}}, alu_a & alu_b};
                ALU_OR:   alu_res = {{WIDTH{1'b0}}, alu_a | alu_b};
                ALU_SHR:  alu_res = {{WIDTH{1'b0}}, alu_a >> shamt};
                ALU_SHRA: alu_res = {{WIDTH{1'b0}}, 32'($signed(alu_a) >>> shamt)};
                ALU_SHL:  alu_res = {{WIDTH{1'b0}}, alu_a << shamt};
                // A shift by 32 yields zero, so a zero rotate amount needs no special case.
                ALU_ROR:  alu_res = {{WIDTH{1'b0}}, (alu_a >> shamt) | (alu_a << shinv)};
                ALU_ROL:  alu_res = {{WIDTH{1'b0}}, (alu_a << shamt) | (alu_a >> shinv)};
                ALU_MUL:  alu_res = product;
                ALU_DIV:  alu_res = {rem, quot};
                ALU_NEG:  alu_res = {{WIDTH{1'b0}}, 32'd0 - alu_b};
                ALU_NOT:  alu_res = {{WIDTH{1'b0}}, ~alu_b};
                default:  alu_res = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_src_datapath.sv
// Directed-vector bench for src_datapath: drives control strobes as a
// micro-sequencer would and checks registers and bus against hand values.
module tb_src_datapath;

    logic        clock;
    logic        clear;
    logic [15:0] rin, rout;
    logic        HIin, LOin, Zhighin, Zlowin, PCin, MDRin, In_Portin, Coutin;
    logic        Read, IRin, MARin, Yin, Zin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout;
    logic        IncPC;
    logic [31:0] Mdatain;
    logic [4:0]  ALU_Control;
    logic [31:0] Out_Portout;

    int n_cmp = 0;
    int n_err = 0;

    src_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .PCin(PCin), .MDRin(MDRin), .In_Portin(In_Portin), .Coutin(Coutin),
        .Read(Read), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .In_Portout(In_Portout), .Coutout(Coutout),
        .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
        .Out_Portout(Out_Portout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0; PCin = 0; MDRin = 0;
        In_Portin = 0; Coutin = 0; Read = 0; IRin = 0; MARin = 0; Yin = 0; Zin = 0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        In_Portout = 0; Coutout = 0; IncPC = 0; Mdatain = '0; ALU_Control = '0;
    endtask

    // One clock edge, then drop every strobe for the next step.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    // Memory -> MDR -> Rn
    task automatic load_r(input logic [31:0] v, input int idx);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
        MDRout = 1; rin[idx] = 1;
        tick();
    endtask

    // Y <- Ra; Z <- Y op Rb
    task automatic alu_op(input int ra, input int rb, input logic [4:0] op);
        rout[ra] = 1; Yin = 1;
        tick();
        rout[rb] = 1; ALU_Control = op; Zin = 1;
        tick();
    endtask

    task automatic z_to_lo_hi();
        Zlowout = 1; LOin = 1;
        tick();
        Zhighout = 1; HIin = 1;
        tick();
    endtask

    initial begin
        idle();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_bus", Out_Portout, 32'h0);
        clear = 1'b1;
        tick();
        check("rst_r5", dut.R5.q, 32'h0);
        check("rst_lo", dut.lo_reg.q, 32'h0);
        check("rst_hi", dut.hi_reg.q, 32'h0);
        check("rst_pc", dut.pc_reg.q, 32'h0);
        check("idle_bus", Out_Portout, 32'h0);

        // MDR load path
        Mdatain = 32'h34; Read = 1; MDRin = 1;
        tick();
        check("mdr_34", dut.mdr_reg.q, 32'h34);
        MDRout = 1; rin[5] = 1;
        #1;
        check("bus_mdr", Out_Portout, 32'h34);
        tick();
        check("r5_34", dut.R5.q, 32'h34);
        load_r(32'h45, 6);
        check("r6_45", dut.R6.q, 32'h45);

        // MUL 0x34 * 0x45 = 3588
        alu_op(5, 6, 5'b01001);
        z_to_lo_hi();
        check("mul_lo", dut.lo_reg.q, 32'h0000_0E04);
        check("mul_hi", dut.hi_reg.q, 32'h0);

        // MUL -2 * 3 = -6
        load_r(32'hFFFF_FFFE, 5);
        load_r(32'h3, 6);
        alu_op(5, 6, 5'b01001);
        z_to_lo_hi();
        check("muls_lo", dut.lo_reg.q, 32'hFFFF_FFFA);
        check("muls_hi", dut.hi_reg.q, 32'hFFFF_FFFF);

        // Fetch increment
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
        tick();
        check("fetch_mar", dut.mar_reg.q, 32'h0);
        Zlowout = 1; PCin = 1;
        tick();
        check("fetch_pc", dut.pc_reg.q, 32'h1);

        // IncPC wraps and ignores ALU_Control
        Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1;
        tick();
        MDRout = 1; PCin = 1;
        tick();
        PCout = 1; IncPC = 1; ALU_Control = 5'b01100; Zin = 1;
        tick();
        check("inc_wrap_lo", dut.zlow_reg.q, 32'h0);
        check("inc_wrap_hi", dut.zhigh_reg.q, 32'h0);

        // DIV 100 / 7 = 14 r 2
        load_r(32'd100, 1);
        load_r(32'd7, 2);
        alu_op(1, 2, 5'b01010);
        check("div_q", dut.zlow_reg.q, 32'h0000_000E);
        check("div_r", dut.zhigh_reg.q, 32'h0000_0002);
        // Divide by zero: no out strobe leaves the bus at 0
        ALU_Control = 5'b01010; Zin = 1;
        tick();
        check("div0_lo", dut.zlow_reg.q, 32'h0);
        check("div0_hi", dut.zhigh_reg.q, 32'h0);
        // -2 / 3 = 0 r -2
        alu_op(5, 6, 5'b01010);
        check("divs_q", dut.zlow_reg.q, 32'h0);
        check("divs_r", dut.zhigh_reg.q, 32'hFFFF_FFFE);

        // Bus priority
        rout[1] = 1; rout[2] = 1;
        #1;
        check("prio_r1_r2", Out_Portout, 32'd100);
        idle();
        rout[2] = 1; HIout = 1;
        #1;
        check("prio_r2_hi", Out_Portout, 32'd7);
        idle();
        HIout = 1; MDRout = 1;
        #1;
        check("prio_hi_mdr", Out_Portout, 32'hFFFF_FFFF);
        idle();

        // SUB 5 - 7
        load_r(32'd5, 3);
        alu_op(3, 2, 5'b00001);
        check("sub_lo", dut.zlow_reg.q, 32'hFFFF_FFFE);
        check("sub_hi", dut.zhigh_reg.q, 32'h0);

        // Shifts and rotates of 0x80000001 by 1
        load_r(32'h8000_0001, 4);
        load_r(32'h1, 7);
        alu_op(4, 7, 5'b01000);
        check("rol", dut.zlow_reg.q, 32'h0000_0003);
        alu_op(4, 7, 5'b00111);
        check("ror", dut.zlow_reg.q, 32'hC000_0000);
        alu_op(4, 7, 5'b00101);
        check("shra", dut.zlow_reg.q, 32'hC000_0000);
        alu_op(4, 7, 5'b00100);
        check("shr", dut.zlow_reg.q, 32'h4000_0000);
        alu_op(4, 7, 5'b00110);
        check("shl", dut.zlow_reg.q, 32'h0000_0002);
        alu_op(4, 7, 5'b11111);
        check("bad_op", dut.zlow_reg.q, 32'h0);

        // ADD, AND, OR, NEG, NOT on 100 and 7
        alu_op(1, 2, 5'b00000);
        check("add", dut.zlow_reg.q, 32'h0000_006B);
        alu_op(1, 2, 5'b00010);
        check("and", dut.zlow_reg.q, 32'h0000_0004);
        alu_op(1, 2, 5'b00011);
        check("or", dut.zlow_reg.q, 32'h0000_0067);
        alu_op(1, 2, 5'b01011);
        check("neg", dut.zlow_reg.q, 32'hFFFF_FFF9);
        alu_op(1, 2, 5'b01100);
        check("not", dut.zlow_reg.q, 32'hFFFF_FFF8);

        // Zhighin loads only the upper half from the bus
        rout[1] = 1; Zhighin = 1;
        tick();
        check("zhigh_load", dut.zhigh_reg.q, 32'd100);
        check("zlow_hold", dut.zlow_reg.q, 32'hFFFF_FFF8);

        // Asynchronous clear mid-run
        #2 clear = 1'b0;
        #1;
        check("async_r1", dut.R1.q, 32'h0);
        clear = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/src_datapath.md
Name: src_datapath

Overview:
- 32-bit single-bus register datapath for the Mini-SRC processor (phase 1).
- Contains R0–R15, HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z, an input-port register, a constant register C, a bus multiplexer and the ALU.
- Every transfer is driven by one-hot control strobes from an external control unit (currently the testbench FSM).
- The block has no sequencing of its own.

Parameters:
- WIDTH, 32, datapath/register width; Z is 2*WIDTH.

Ports:
- clock  in  1  system clock; all registers update on the rising edge.
- clear  in  1  asynchronous, active-low reset; the codebase name is "clear".
- R0in..R15in  in  1 each  load general register Rn from the bus.
- HIin, LOin  in  1  load HI / LO from the bus.
- Zhighin, Zlowin  in  1  load Z[63:32] / Z[31:0] from the bus.
- PCin, MDRin, In_Portin, Coutin  in  1  load PC / MDR / input-port register / C register.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- IRin, MARin, Yin  in  1  load IR / MAR / Y from the bus.
- Zin  in  1  load the 64-bit Z from the ALU result.
- R0out..R15out  in  1 each  drive Rn onto the bus.
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout  in  1  drive the named source onto the bus.
- IncPC  in  1  ALU computes bus+1, overriding ALU_Control.
- Mdatain  in  32  memory read data.
- ALU_Control  in  5  ALU operation select.
- Out_Portout  out  32  current bus value (combinational observability port).

Behaviour:
- Reset: while clear=0, every register is 0, asynchronously. Out_Portout follows the bus, which is then 0.
- Registers:
  - Each register loads on the rising edge when its enable is high, otherwise it holds.
  - MDR loads Read ? Mdatain : bus.
  - R0 is an ordinary register; it is not hard-wired to zero in this phase.
- Bus:
  - Combinational priority mux. Order: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, In_Port, C.
  - No out strobe asserted → bus = 0.
  - Multiple strobes asserted → the highest priority wins.
- ALU operands: A = Y, B = bus. The result is 64 bits and is latched into Z when Zin=1.
- Z load priority: Zin beats Zhighin/Zlowin. Zhighin and Zlowin without Zin load their half from the bus.
- ALU_Control encoding. 32-bit results are zero-extended into Z[63:32].
  - 00000 ADD, 00001 SUB (A−B), 00010 AND, 00011 OR.
  - 00100 SHR (logical), 00101 SHRA (arithmetic), 00110 SHL. Shift amount = B[4:0].
  - 00111 ROR, 01000 ROL. Rotate amount = B[4:0].
  - 01001 MUL: signed 32x32 → 64; Z = full product (low half in Z[31:0]).
  - 01010 DIV: signed; Z[31:0] = quotient truncated toward zero, Z[63:32] = remainder with the sign of A. B=0 → Z=0.
  - 01011 NEG (−B), 01100 NOT (~B).
  - All other codes → Z=0.
- IncPC=1: result = {32'b0, bus+1} regardless of ALU_Control. Wraps FFFFFFFF → 00000000.
- Latency:
  - Every transfer is one clock edge.
  - A register value reaches the bus in the same cycle its out strobe is asserted.
  - The ALU is purely combinational; MUL and DIV also complete in one cycle.
- Hierarchy for probing: general register instances are named R0..R15, HI is hi_reg, LO is lo_reg. Each instance exposes its contents as q.

Decomposition:
- Shared package: WIDTH and the ALU_Control opcode constants (ALU_ADD..ALU_NOT).
- Natural sub-module: register32 (clock, clear, enable, d, q). Instantiate it for every 32-bit register.
- ALU and bus mux stay inside src_datapath.

Test Plan:
- Reset: hold clear=0, then release → R5, LO, HI, PC all read 00000000; with no out strobe, Out_Portout = 0.
- MDR load path:
  - Mdatain=34, Read=1, MDRin → MDR=34; next cycle MDRout+R5in → R5=00000034.
  - Same sequence with 45 → R6=00000045.
- MUL:
  - R5out+Yin, then R6out + ALU_Control=01001 + Zin.
  - Then Zlowout+LOin and Zhighout+HIin.
  - → LO=00000E04, HI=00000000.
  - Repeat with R5=FFFFFFFE, R6=3 → LO=FFFFFFFA, HI=FFFFFFFF.
- Fetch increment: PC=0; PCout+MARin+IncPC+Zin, then Zlowout+PCin → MAR=0, PC=00000001.
- DIV: Y=100, bus=7, ALU_Control=01010 → Z[31:0]=0000000E, Z[63:32]=00000002. Divisor 0 → Z=0.
- Bus priority and ops:
  - R1out and R2out asserted together → bus = R1.
  - SUB 5−7 → Z[31:0]=FFFFFFFE.
  - ROL 80000001 by 1 → 00000003.
